ex_mem_pipe_reg: RTL and testbench

Next-generation EX→MEM pipeline register with a ready/valid handshake on both sides and a 2-entry skid buffer. It allows MEM-side stalls without a combinational ready path back to EX, and supports a synchronous flush for branch/exception squash. It sits between the EX stage and the MEM stage and replaces the plain always-load EX/MEM register. It adds stall, flush, bubble qualification of control bits, and an occupancy count.

---
 rtl/ex_mem_pipe_reg.sv | 166 ++++++++++++++++
 tb/tb_ex_mem_pipe_reg.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_pipe_reg
// EX->MEM pipeline register with ready/valid handshakes on both sides and a
// two-entry (main + skid) buffer. in_ready comes from registered state only,
// so a MEM-side stall never forms a combinational path back into EX.
//
// Ports
//   clk                       rising-edge clock
//   rst                       synchronous, active-low reset
//   flush                     synchronous squash of all held entries
//   in_valid / in_ready       EX-side handshake
//   WB_EN_in, MEM_R_EN_in,
//   MEM_W_EN_in               control bits from EX
//   ALU_Res_in, Val_Rm_in     ALU result / address and store data
//   Dest_in                   destination register index
//   out_valid / out_ready     MEM-side handshake
//   WB_EN, MEM_R_EN, MEM_W_EN control bits of the head entry, forced to 0
//                             when out_valid is 0
//   ALU_Res, Val_Rm, Dest     payload of the head (main) entry
//   occupancy                 number of held entries (0, 1 or 2)
// ---------------------------------------------------------------------------
module ex_mem_pipe_reg #(
  parameter int DATA_LEN             = 32,
  parameter int ADDRESS_LEN_REG_FILE = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            WB_EN_in,
  input  logic                            MEM_R_EN_in,
  input  logic                            MEM_W_EN_in,
  input  logic [DATA_LEN-1:0]             ALU_Res_in,
  input  logic [DATA_LEN-1:0]             Val_Rm_in,
  input  logic [ADDRESS_LEN_REG_FILE-1:0] Dest_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            WB_EN,
  output logic                            MEM_R_EN,
  output logic                            MEM_W_EN,
  output logic [DATA_LEN-1:0]             ALU_Res,
  output logic [DATA_LEN-1:0]             Val_Rm,
  output logic [ADDRESS_LEN_REG_FILE-1:0] Dest,
  output logic [1:0]                      occupancy
);

  // One buffered instruction: control bits followed by payload.
  typedef struct packed {
    logic                            wb_en;
    logic                            mem_r_en;
    logic                            mem_w_en;
    logic [DATA_LEN-1:0]             alu_res;
    logic [DATA_LEN-1:0]             val_rm;
    logic [ADDRESS_LEN_REG_FILE-1:0] dest;
  } entry_t;

  // Validity of main/skid is carried entirely by the state encoding.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  // Squash helper: keeps payload, drops control bits so a stale entry can
  // never write memory or the register file.
  function automatic entry_t clr_ctrl(input entry_t e);
    entry_t r;
    r          = e;
    r.wb_en    = 1'b0;
    r.mem_r_en = 1'b0;
    r.mem_w_en = 1'b0;
    return r;
  endfunction

  state_t r_state;
  entry_t r_main;
  entry_t r_skid;
  entry_t w_in;
  logic   w_acc;
  logic   w_drn;

  assign w_in = '{wb_en:    WB_EN_in,
                  mem_r_en: MEM_R_EN_in,
                  mem_w_en: MEM_W_EN_in,
                  alu_res:  ALU_Res_in,
                  val_rm:   Val_Rm_in,
                  dest:     Dest_in};

  assign in_ready  = (r_state != ST_SKID);
  assign out_valid = (r_state != ST_EMPTY);
  assign w_acc     = in_valid & in_ready;
  assign w_drn     = out_valid & out_ready;

  // Head-entry outputs; control bits are qualified so bubbles are inert.
  assign WB_EN    = r_main.wb_en    & out_valid;
  assign MEM_R_EN = r_main.mem_r_en & out_valid;
  assign MEM_W_EN = r_main.mem_w_en & out_valid;
  assign ALU_Res  = r_main.alu_res;
  assign Val_Rm   = r_main.val_rm;
  assign Dest     = r_main.dest;

  // Occupancy decode from the registered state.
  always_comb begin
    occupancy = 2'd0;
    case (r_state)
      ST_EMPTY: occupancy = 2'd0;
      ST_FULL:  occupancy = 2'd1;
      ST_SKID:  occupancy = 2'd2;
      default:  occupancy = 2'd0;
    endcase
  end

  // Buffer FSM: reset beats flush, flush beats any handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      // A same-cycle accept is discarded; a same-cycle drain already
      // completed on the MEM side and is simply not re-presented.
      r_state <= ST_EMPTY;
      r_main  <= clr_ctrl(r_main);
      r_skid  <= clr_ctrl(r_skid);
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_main  <= w_in;
            r_state <= ST_FULL;
          end else begin
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_acc && w_drn) begin
            r_main  <= w_in;
            r_state <= ST_FULL;
          end else if (w_acc) begin
            // MEM stalled: park the younger instruction behind main.
            r_skid  <= w_in;
            r_state <= ST_SKID;
          end else if (w_drn) begin
            r_state <= ST_EMPTY;
          end else begin
            r_state <= ST_FULL;
          end
        end
        ST_SKID: begin
          // in_ready is low here, so only a drain can move things.
          if (w_drn) begin
            r_main  <= r_skid;
            r_state <= ST_FULL;
          end else begin
            r_state <= ST_SKID;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_pipe_reg
// Directed bench for ex_mem_pipe_reg: reset, streaming, stall/skid, flush,
// bubble qualification and mid-operation reset, with hand-computed values.
// ---------------------------------------------------------------------------
module tb_ex_mem_pipe_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        WB_EN_in;
  logic        MEM_R_EN_in;
  logic        MEM_W_EN_in;
  logic [31:0] ALU_Res_in;
  logic [31:0] Val_Rm_in;
  logic [3:0]  Dest_in;
  logic        out_valid;
  logic        out_ready;
  logic        WB_EN;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_Res;
  logic [31:0] Val_Rm;
  logic [3:0]  Dest;
  logic [1:0]  occupancy;

  int n_tests;
  int n_fail;

  ex_mem_pipe_reg #(
    .DATA_LEN             (32),
    .ADDRESS_LEN_REG_FILE (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .WB_EN_in    (WB_EN_in),
    .MEM_R_EN_in (MEM_R_EN_in),
    .MEM_W_EN_in (MEM_W_EN_in),
    .ALU_Res_in  (ALU_Res_in),
    .Val_Rm_in   (Val_Rm_in),
    .Dest_in     (Dest_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .WB_EN       (WB_EN),
    .MEM_R_EN    (MEM_R_EN),
    .MEM_W_EN    (MEM_W_EN),
    .ALU_Res     (ALU_Res),
    .Val_Rm      (Val_Rm),
    .Dest        (Dest),
    .occupancy   (occupancy)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled off-edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wb, input logic mr, input logic mw,
                       input logic [31:0] alu, input logic [31:0] rm, input logic [3:0] dst);
    in_valid    = v;
    WB_EN_in    = wb;
    MEM_R_EN_in = mr;
    MEM_W_EN_in = mw;
    ALU_Res_in  = alu;
    Val_Rm_in   = rm;
    Dest_in     = dst;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] alu, input logic [1:0] occ);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_alu"},   ALU_Res,        alu);
    chk({tag, "_occ"},   32'(occupancy), 32'(occ));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_occ"},   32'(occupancy), 32'd0);
    chk({tag, "_rdy"},   32'(in_ready),  32'd1);
    chk({tag, "_wb"},    32'(WB_EN),     32'd0);
    chk({tag, "_mr"},    32'(MEM_R_EN),  32'd0);
    chk({tag, "_mw"},    32'(MEM_W_EN),  32'd0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, $urandom, $urandom, 4'($urandom));

    // Reset held for two edges with traffic present.
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b1, $urandom, $urandom, 4'($urandom));
    step();
    chk_empty("rst");
    chk("rst_alu",  ALU_Res,     32'h0);
    chk("rst_rm",   Val_Rm,      32'h0);
    chk("rst_dest", 32'(Dest),   32'h0);

    // Streaming at full rate: one-cycle latency, occupancy stays 1.
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'hA1, 4'd1);
    step();
    chk_head("s1", 32'h10, 2'd1);
    chk("s1_wb",   32'(WB_EN),    32'd1);
    chk("s1_rm",   Val_Rm,        32'hA1);
    chk("s1_dest", 32'(Dest),     32'd1);
    chk("s1_rdy",  32'(in_ready), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'hA2, 4'd2);
    step();
    chk_head("s2", 32'h20, 2'd1);
    chk("s2_dest", 32'(Dest),     32'd2);
    chk("s2_rdy",  32'(in_ready), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h30, 32'hA3, 4'd3);
    step();
    chk_head("s3", 32'h30, 2'd1);
    chk("s3_mr",  32'(MEM_R_EN), 32'd1);
    chk("s3_rm",  Val_Rm,        32'hA3);
    idle();
    step();
    chk_empty("s_end");

    // Stall into the skid entry, then drain in order.
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h11, 32'hB1, 4'd4);
    step();
    chk_head("k1", 32'h11, 2'd1);
    chk("k1_rdy", 32'(in_ready), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h22, 32'hB2, 4'd5);
    step();
    chk_head("k2", 32'h11, 2'd2);
    chk("k2_rdy", 32'(in_ready), 32'd0);
    // Offer another word while full: must not be taken.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h99, 32'hB9, 4'd9);
    step();
    chk_head("k3", 32'h11, 2'd2);
    chk("k3_dest", 32'(Dest), 32'd4);
    idle();
    out_ready = 1'b1;
    step();
    chk_head("k4", 32'h22, 2'd1);
    chk("k4_rdy",  32'(in_ready), 32'd1);
    chk("k4_mr",   32'(MEM_R_EN), 32'd1);
    chk("k4_wb",   32'(WB_EN),    32'd0);
    chk("k4_dest", 32'(Dest),     32'd5);
    step();
    chk_empty("k_end");

    // Flush with both entries held and a new input offered the same cycle.
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h44, 32'hC4, 4'd6);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h55, 32'hC5, 4'd7);
    step();
    chk("f_pre_occ", 32'(occupancy), 32'd2);
    chk("f_pre_mw",  32'(MEM_W_EN),  32'd1);
    flush = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h33, 32'hC3, 4'd8);
    step();
    chk_empty("f1");
    flush = 1'b0;
    idle();
    out_ready = 1'b1;
    step();
    chk_empty("f2");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h66, 32'hC6, 4'd10);
    step();
    chk_head("f3", 32'h66, 2'd1);
    chk("f3_mw", 32'(MEM_W_EN), 32'd0);
    idle();
    step();
    chk_empty("f4");

    // Bubble qualification: stored MEM_W_EN=1 must not leak once drained.
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h77, 32'hD7, 4'd11);
    step();
    chk_head("b1", 32'h77, 2'd1);
    chk("b1_mw", 32'(MEM_W_EN), 32'd1);
    idle();
    out_ready = 1'b1;
    step();
    chk_empty("b2");
    step();
    chk_empty("b3");

    // Reset in the middle of a two-entry backlog.
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h81, 32'hE1, 4'd12);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h82, 32'hE2, 4'd13);
    step();
    chk("r_pre_occ", 32'(occupancy), 32'd2);
    rst = 1'b0;
    idle();
    step();
    chk_empty("r1");
    chk("r1_alu",  ALU_Res,   32'h0);
    chk("r1_rm",   Val_Rm,    32'h0);
    chk("r1_dest", 32'(Dest), 32'h0);
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h91, 32'hF1, 4'd14);
    step();
    chk_head("r2", 32'h91, 2'd1);
    chk("r2_dest", 32'(Dest), 32'd14);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h92, 32'hF2, 4'd15);
    step();
    chk_head("r3", 32'h92, 2'd1);
    chk("r3_rm", Val_Rm, 32'hF2);
    idle();
    step();
    chk_empty("r4");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
